// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RV32 instruction encoder.
// Format and error codes match the loader interface encoding.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4,
    FMT_R = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_BADFMT   = 2'd3
  } err_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -(1 << 20);
  localparam int IMM_J_MAX = (1 << 20) - 2;

  function automatic logic imm_fits(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: format, register fields and a 32-bit immediate to an RV32 word.
// Bit placement mirrors the decoder's immediate extraction so decode(encode(x)) == x.
module imm_pack
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output err_e        err_o
);

  always_comb begin
    word_o = '0;
    err_o  = ERR_NONE;
    case (fmt_e'(fmt_i))
      FMT_I: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        if (!imm_fits(imm_i, IMM12_MIN, IMM12_MAX)) err_o = ERR_RANGE;
      end
      FMT_S: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        if (!imm_fits(imm_i, IMM12_MIN, IMM12_MAX)) err_o = ERR_RANGE;
      end
      FMT_B: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                  opcode_i};
        if (imm_i[0]) begin
          err_o = ERR_MISALIGN;
        end else if (!imm_fits(imm_i, IMM_B_MIN, IMM_B_MAX)) begin
          err_o = ERR_RANGE;
        end
      end
      FMT_U: begin
        word_o = {imm_i[31:12], rd_i, opcode_i};
        if (imm_i[11:0] != 12'd0) err_o = ERR_MISALIGN;
      end
      FMT_J: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        if (imm_i[0]) begin
          err_o = ERR_MISALIGN;
        end else if (!imm_fits(imm_i, IMM_J_MIN, IMM_J_MAX)) begin
          err_o = ERR_RANGE;
        end
      end
      FMT_R: begin
        word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      default: begin
        err_o = ERR_BADFMT;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder for the program-loader path: packs requests into RV32 words, assigns
// sequential write addresses, reports rejected requests and counts words delivered.
module instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  word_count
);

  logic [31:0]       pack_word;
  err_e              pack_err;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_valid_q, err_valid_d;
  err_e              err_code_q, err_code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic [ADDR_W-1:0] base_aligned;
  logic [ADDR_W-1:0] addr_sel;
  logic              unused_base_lsbs;

  imm_pack u_imm_pack (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .word_o   (pack_word),
    .err_o    (pack_err)
  );

  assign unused_base_lsbs = ^base_addr[1:0];
  assign base_aligned     = {base_addr[ADDR_W-1:2], 2'b00};
  assign in_ready         = ~out_valid_q | out_ready;
  assign accept           = in_valid & in_ready;
  // A base load in the same cycle as an accept applies to that word.
  assign addr_sel         = load_base ? base_aligned : addr_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    addr_d      = addr_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    cnt_d       = cnt_q;

    if (load_base) addr_d = base_aligned;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + CNT_W'(1);
    end

    if (accept) begin
      if (pack_err == ERR_NONE) begin
        out_valid_d = 1'b1;
        out_instr_d = pack_word;
        out_addr_d  = addr_sel;
        addr_d      = addr_sel + ADDR_W'(4);
      end else begin
        // Rejected requests are consumed without touching the address counter.
        err_valid_d = 1'b1;
        err_code_d  = pack_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      addr_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      addr_q      <= addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_addr   = out_addr_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, hand-written multi-cycle sequences and a
// randomized run scored against an arithmetic reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_base;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] word_count;

  int n_vec  = 0;
  int n_fail = 0;

  instr_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .load_base  (load_base),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_word;
    logic [1:0]  exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_fmt    = v.fmt;
    in_opcode = v.opc;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
  endtask

  function automatic vec_t addi(input logic [4:0] rd);
    vec_t v;
    v = '{3'd0, 7'b0010011, rd, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'd0, 2'd0};
    return v;
  endfunction

  // Reference: field placement by shifts and masks, range checks as signed integers.
  function automatic logic [33:0] model(input vec_t v);
    logic [31:0] u, w, op, rd, r1, r2, f3, f7;
    int s;
    logic [1:0] e;
    u = v.imm; s = $signed(v.imm); e = 2'd0; w = 32'd0;
    op = 32'(v.opc); rd = 32'(v.rd); r1 = 32'(v.rs1); r2 = 32'(v.rs2);
    f3 = 32'(v.f3); f7 = 32'(v.f7);
    case (v.fmt)
      3'd0: begin
        if (s < -2048 || s > 2047) e = 2'd1;
        w = (u << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      3'd1: begin
        if (s < -2048 || s > 2047) e = 2'd1;
        w = (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
          | ((u & 32'h1F) << 7) | op;
      end
      3'd2: begin
        if (u % 2 != 0) e = 2'd2;
        else if (s < -4096 || s > 4094) e = 2'd1;
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (r2 << 20) | (r1 << 15)
          | (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | op;
      end
      3'd3: begin
        if (u % 4096 != 0) e = 2'd2;
        w = (u & 32'hFFFFF000) | (rd << 7) | op;
      end
      3'd4: begin
        if (u % 2 != 0) e = 2'd2;
        else if (s < -(1 << 20) || s > (1 << 20) - 2) e = 2'd1;
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
          | (((u >> 12) & 255) << 12) | (rd << 7) | op;
      end
      3'd5: w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
      default: e = 2'd3;
    endcase
    return {e, w};
  endfunction

  // Random-phase scoreboard state
  logic [63:0] exp_q[$];
  logic [31:0] ref_addr;
  logic        err_pend;
  logic [1:0]  last_err;
  int          hs_count;

  int bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098,
                  -1048576, 1048574, 1048576, -1048578, 4095, 0};

  task automatic rand_step(input bit active);
    vec_t v;
    logic [33:0] m;
    logic [31:0] a;
    @(negedge clk);
    chk("rnd_out_valid", out_valid, exp_q.size() != 0);
    chk("rnd_err_valid", err_valid, err_pend);
    chk("rnd_err_code", err_code, last_err);
    v.fmt = 3'($urandom_range(0, 7));
    v.opc = 7'($urandom); v.rd = 5'($urandom); v.rs1 = 5'($urandom);
    v.rs2 = 5'($urandom); v.f3 = 3'($urandom); v.f7 = 7'($urandom);
    case ($urandom_range(0, 5))
      0: v.imm = $urandom;
      1: v.imm = 32'($urandom_range(0, 200)) - 32'd100;
      2: v.imm = 32'(bnd[$urandom_range(0, 13)]);
      3: v.imm = $urandom << 12;
      4: v.imm = ($urandom & 32'h1FFFFE) - 32'h100000;
      default: v.imm = 32'($urandom_range(0, 8190)) - 32'd4096;
    endcase
    drive(v);
    in_valid  = active && ($urandom_range(0, 9) < 7);
    out_ready = !active || ($urandom_range(0, 9) < 6);
    load_base = active && ($urandom_range(0, 99) < 3);
    base_addr = $urandom;
    #1;
    chk("rnd_in_ready", in_ready, !out_valid || out_ready);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("rnd_unexpected_word", 1'b1, 1'b0);
      end else begin
        chk("rnd_word", {out_addr, out_instr}, exp_q.pop_front());
        hs_count++;
      end
    end
    err_pend = 1'b0;
    if (in_valid && in_ready) begin
      m = model(v);
      if (m[33:32] == 2'd0) begin
        a = load_base ? (base_addr & 32'hFFFFFFFC) : ref_addr;
        exp_q.push_back({a, m[31:0]});
        ref_addr = a + 32'd4;
      end else begin
        err_pend = 1'b1;
        last_err = m[33:32];
        if (load_base) ref_addr = base_addr & 32'hFFFFFFFC;
      end
    end else if (load_base) begin
      ref_addr = base_addr & 32'hFFFFFFFC;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[13];
    logic [31:0] exp_addr;
    int k, popped;

    tbl[0]  = '{3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 2'd0};
    tbl[1]  = '{3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 2'd0};
    tbl[2]  = '{3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFE000EE3, 2'd0};
    tbl[3]  = '{3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0, 2'd2};
    tbl[4]  = '{3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 2'd0};
    tbl[5]  = '{3'd3, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7,
                2'd0};
    tbl[6]  = '{3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0, 2'd1};
    tbl[7]  = '{3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0, 2'd3};
    tbl[8]  = '{3'd5, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 32'h003100B3, 2'd0};
    tbl[9]  = '{3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h0, 2'd1};
    tbl[10] = '{3'd4, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 32'h8000006F,
                2'd0};
    tbl[11] = '{3'd3, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h0, 2'd2};
    tbl[12] = '{3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h7FFFFFFF, 32'h0, 2'd3};

    rst = 1'b1; load_base = 1'b0; base_addr = '0; in_valid = 1'b0; out_ready = 1'b1;
    drive(tbl[0]);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_instr", out_instr, 32'h0);
    chk("reset_out_addr", out_addr, 32'h0);
    chk("reset_err_valid", err_valid, 1'b0);
    chk("reset_err_code", err_code, 2'd0);
    chk("reset_word_count", word_count, 16'd0);
    chk("reset_in_ready", in_ready, 1'b1);

    // Base with nonzero low bits: they must be dropped.
    load_base = 1'b1; base_addr = 32'h103;
    @(negedge clk);
    load_base = 1'b0;

    exp_addr = 32'h100;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      in_valid = 1'b1;
      #1 chk("dir_in_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      if (tbl[i].exp_err == 2'd0) begin
        chk("dir_out_valid", out_valid, 1'b1);
        chk("dir_out_instr", out_instr, tbl[i].exp_word);
        chk("dir_out_addr", out_addr, exp_addr);
        chk("dir_no_err", err_valid, 1'b0);
        exp_addr += 32'd4;
      end else begin
        chk("dir_no_word", out_valid, 1'b0);
        chk("dir_err_valid", err_valid, 1'b1);
        chk("dir_err_code", err_code, tbl[i].exp_err);
      end
    end
    @(negedge clk);
    chk("dir_word_count", word_count, 16'd7);
    chk("dir_err_pulse_end", err_valid, 1'b0);
    chk("dir_err_code_held", err_code, 2'd3);

    // Backpressure: hold the first word for three cycles, then stream.
    load_base = 1'b1; base_addr = 32'h200;
    @(negedge clk);
    load_base = 1'b0;
    k = 0; popped = 0;
    for (int cyc = 0; cyc < 20 && popped < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_ready = (cyc >= 4);
      drive(addi(5'(k + 1)));
      in_valid = (k < 4);
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_addr_stable", out_addr, 32'h200);
        chk("bp_instr_stable", out_instr, 32'h00500093);
      end
      if (out_valid && out_ready) begin
        chk("bp_addr", out_addr, 32'h200 + 32'(4 * popped));
        chk("bp_instr", out_instr, 32'h00500013 | (32'(popped + 1) << 7));
        popped++;
      end
      if (in_valid && in_ready) k++;
    end
    chk("bp_all_drained", 64'(popped), 64'd4);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_word_count", word_count, 16'd11);

    // Base load coinciding with an accept, then address wrap.
    load_base = 1'b1; base_addr = 32'hFFFFFFFC; drive(addi(5'd1)); in_valid = 1'b1;
    @(negedge clk);
    load_base = 1'b0; drive(addi(5'd2));
    chk("wrap_first_addr", out_addr, 32'hFFFFFFFC);
    @(negedge clk);
    in_valid = 1'b0;
    chk("wrap_second_addr", out_addr, 32'h0);
    chk("wrap_second_instr", out_instr, 32'h00500113);

    // Reset while a word is held.
    @(negedge clk);
    drive(addi(5'd3)); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_word_count", word_count, 16'd0);
    chk("rst_mid_err_code", err_code, 2'd0);

    // Randomized run against the reference model.
    ref_addr = 32'h0; err_pend = 1'b0; last_err = 2'd0; hs_count = 0;
    repeat (3000) rand_step(1'b1);
    repeat (4) rand_step(1'b0);
    chk("rnd_word_count", word_count, 16'(hs_count));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
